// File: rtl/regfile_pkg.sv
// Shared register-file types and constants, used by both the write-side
// front end and the read side.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        reg_onehot    = '0;
        reg_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_writer_if.sv
// Producer handshakes and the register-file write port of the write-side
// front end. The master is the producer/regfile side; the slave is regfile_writer.
interface regfile_writer_if;
    import regfile_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              wr_hold;
    logic              wr_en;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wr_hold,
        input  alu_ready, mem_ready, wr_en, write_register, write_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wr_hold,
        output alu_ready, mem_ready, wr_en, write_register, write_data
    );

endinterface

// File: rtl/regfile_wq.sv
// In-order write queue: up to two pushes (push0 is older) and one pop per cycle.
// Storage and valid bits are exposed so the top can run the forwarding lookup.
module regfile_wq
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push0,
    input  wq_entry_t                   push0_entry,
    input  logic                        push1,
    input  wq_entry_t                   push1_entry,
    input  logic                        pop,
    output wq_entry_t [DEPTH-1:0]       slots,
    output logic      [DEPTH-1:0]       slot_valid,
    output logic      [IDX_W-1:0]       head_idx,
    output logic      [PTR_W-1:0]       count,
    output logic                        empty
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] wr_idx_next;
    logic [PTR_W-1:0] n_push;
    wq_entry_t        first_entry;

    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign head_idx    = rd_ptr[IDX_W-1:0];
    assign wr_idx      = wr_ptr[IDX_W-1:0];
    assign wr_idx_next = wr_idx + IDX_W'(1);
    assign n_push      = PTR_W'(push0) + PTR_W'(push1);
    // A lone push1 still lands in the first free slot.
    assign first_entry = push0 ? push0_entry : push1_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            slot_valid <= '0;
        end else begin
            if (pop) begin
                slot_valid[head_idx] <= 1'b0;
                rd_ptr               <= rd_ptr + PTR_W'(1);
            end
            if (push0 || push1) begin
                slots[wr_idx]      <= first_entry;
                slot_valid[wr_idx] <= 1'b1;
            end
            if (push0 && push1) begin
                slots[wr_idx_next]      <= push1_entry;
                slot_valid[wr_idx_next] <= 1'b1;
            end
            wr_ptr <= wr_ptr + n_push;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Write-side front end of the register file: accepts ALU and load results,
// queues them in order, drains one per cycle and forwards uncommitted values.
module regfile_writer
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_writer_if.slave       bus,
    input  logic [ADDR_W-1:0]     fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic [CNT_W-1:0]      count
);

    wq_entry_t [DEPTH-1:0] slots;
    logic      [DEPTH-1:0] slot_valid;
    logic      [IDX_W-1:0] head_idx;
    logic      [IDX_W-1:0] fwd_idx;
    logic      [CNT_W-1:0] free;
    logic                  empty;
    logic                  pop_en;
    logic                  mem_push;
    logic                  alu_push;

    // Room is judged on the pre-pop occupancy; the load path gets the last slot.
    assign free          = CNT_W'(DEPTH) - count;
    assign bus.mem_ready = !rst && (free != '0);
    assign bus.alu_ready = !rst && ((free > CNT_W'(1)) || ((free != '0) && !bus.mem_valid));

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_rd != ZERO_REG);
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != ZERO_REG);

    assign pop_en             = !rst && !empty && !bus.wr_hold;
    assign bus.wr_en          = pop_en;
    assign bus.write_register = empty ? '0 : slots[head_idx].addr;
    assign bus.write_data     = empty ? '0 : slots[head_idx].data;

    regfile_wq #(.DEPTH(DEPTH)) u_wq (
        .clk         (clk),
        .rst         (rst),
        .push0       (mem_push),
        .push0_entry ('{addr: bus.mem_rd, data: bus.mem_data}),
        .push1       (alu_push),
        .push1_entry ('{addr: bus.alu_rd, data: bus.alu_data}),
        .pop         (pop_en),
        .slots       (slots),
        .slot_valid  (slot_valid),
        .head_idx    (head_idx),
        .count       (count),
        .empty       (empty)
    );

    // Walk oldest to youngest from the head so the last match is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_idx + IDX_W'(k);
            if (slot_valid[fwd_idx] && (slots[fwd_idx].addr == fwd_addr) && (fwd_addr != ZERO_REG)) begin
                fwd_hit  = 1'b1;
                fwd_data = slots[fwd_idx].data;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                pend_mask = pend_mask | reg_onehot(slots[i].addr);
            end
        end
        pend_mask[ZERO_REG] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: hand-computed expectations per step plus
// an in-order log of every committed register write.
module tb_regfile_writer;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [NUM_REGS-1:0] pend_mask;
    logic [2:0]        count;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W+DATA_W-1:0] wr_log [$];

    logic [ADDR_W-1:0] exp_rd   [11] = '{5'd3, 5'd1, 5'd2, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd5, 5'd5, 5'd10};
    logic [DATA_W-1:0] exp_data [11] = '{32'h5, 32'h2, 32'h3, 32'h40, 32'h60, 32'h70, 32'h80, 32'h90,
                                         32'h11, 32'h22, 32'hA};

    regfile_writer_if rf_bus();

    regfile_writer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (rf_bus),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .pend_mask (pend_mask),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_bus.wr_en) wr_log.push_back({rf_bus.write_register, rf_bus.write_data});
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                                 input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad);
        rf_bus.mem_valid = mv;
        rf_bus.mem_rd    = mrd;
        rf_bus.mem_data  = md;
        rf_bus.alu_valid = av;
        rf_bus.alu_rd    = ard;
        rf_bus.alu_data  = ad;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        fwd_addr       = '0;
        rf_bus.wr_hold = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_wr_en", 32'(rf_bus.wr_en), 0);
        checkOutput("rst_pend", pend_mask, 0);
        checkOutput("rst_alu_ready", 32'(rf_bus.alu_ready), 0);
        checkOutput("rst_mem_ready", 32'(rf_bus.mem_ready), 0);
        rst = 1'b0;
        #1;
        checkOutput("idle_alu_ready", 32'(rf_bus.alu_ready), 1);
        checkOutput("idle_mem_ready", 32'(rf_bus.mem_ready), 1);
        tick();

        // Single ALU write
        applyStimulus(0, 0, 0, 1, 5'd3, 32'h5);
        checkOutput("single_alu_ready", 32'(rf_bus.alu_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("single_count", 32'(count), 1);
        checkOutput("single_wr_en", 32'(rf_bus.wr_en), 1);
        checkOutput("single_wreg", 32'(rf_bus.write_register), 3);
        checkOutput("single_wdata", rf_bus.write_data, 32'h5);
        tick();
        checkOutput("single_count_after", 32'(count), 0);
        checkOutput("single_wr_en_after", 32'(rf_bus.wr_en), 0);

        // Simultaneous mem + ALU
        applyStimulus(1, 5'd1, 32'h2, 1, 5'd2, 32'h3);
        checkOutput("sim_mem_ready", 32'(rf_bus.mem_ready), 1);
        checkOutput("sim_alu_ready", 32'(rf_bus.alu_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sim_count", 32'(count), 2);
        checkOutput("sim_wreg0", 32'(rf_bus.write_register), 1);
        checkOutput("sim_wdata0", rf_bus.write_data, 32'h2);
        checkOutput("sim_pend", pend_mask, 32'h6);
        tick();
        checkOutput("sim_wreg1", 32'(rf_bus.write_register), 2);
        checkOutput("sim_wdata1", rf_bus.write_data, 32'h3);
        checkOutput("sim_pend1", pend_mask, 32'h4);
        tick();
        checkOutput("sim_count_after", 32'(count), 0);

        // Full queue and load priority
        rf_bus.wr_hold = 1'b1;
        applyStimulus(1, 5'd4, 32'h40, 1, 5'd6, 32'h60);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h70);
        checkOutput("full_alu_ready_free2", 32'(rf_bus.alu_ready), 1);
        tick();
        applyStimulus(1, 5'd8, 32'h80, 1, 5'd9, 32'h90);
        checkOutput("free1_mem_ready", 32'(rf_bus.mem_ready), 1);
        checkOutput("free1_alu_ready", 32'(rf_bus.alu_ready), 0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h90);
        checkOutput("full_count", 32'(count), 4);
        checkOutput("full_mem_ready", 32'(rf_bus.mem_ready), 0);
        checkOutput("full_alu_ready", 32'(rf_bus.alu_ready), 0);
        checkOutput("hold_wr_en", 32'(rf_bus.wr_en), 0);
        tick();
        checkOutput("hold_count", 32'(count), 4);
        rf_bus.wr_hold = 1'b0;
        #1;
        checkOutput("full_pop_alu_ready", 32'(rf_bus.alu_ready), 0);
        checkOutput("full_pop_wr_en", 32'(rf_bus.wr_en), 1);
        checkOutput("full_pop_wreg", 32'(rf_bus.write_register), 4);
        tick();
        checkOutput("after_pop_count", 32'(count), 3);
        checkOutput("after_pop_alu_ready", 32'(rf_bus.alu_ready), 1);
        checkOutput("after_pop_wreg", 32'(rf_bus.write_register), 6);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("pushpop_count", 32'(count), 3);
        checkOutput("pushpop_wreg", 32'(rf_bus.write_register), 7);
        tick();
        tick();
        tick();
        checkOutput("drain_count", 32'(count), 0);

        // Forwarding of the youngest match
        rf_bus.wr_hold = 1'b1;
        applyStimulus(0, 0, 0, 1, 5'd5, 32'h11);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd5, 32'h22);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        fwd_addr = 5'd5;
        #1;
        checkOutput("fwd_hit", 32'(fwd_hit), 1);
        checkOutput("fwd_data", fwd_data, 32'h22);
        checkOutput("fwd_pend", pend_mask, 32'h20);
        fwd_addr = 5'd0;
        #1;
        checkOutput("fwd_r0_hit", 32'(fwd_hit), 0);
        checkOutput("fwd_r0_data", fwd_data, 0);
        fwd_addr = 5'd6;
        #1;
        checkOutput("fwd_miss_hit", 32'(fwd_hit), 0);

        // Zero register discarded
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hDEADBEEF);
        checkOutput("zero_alu_ready", 32'(rf_bus.alu_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("zero_count", 32'(count), 2);
        checkOutput("zero_wr_en", 32'(rf_bus.wr_en), 0);
        rf_bus.wr_hold = 1'b0;
        tick();
        tick();
        checkOutput("fwd_drain_count", 32'(count), 0);

        // Reset mid-drain
        rf_bus.wr_hold = 1'b1;
        applyStimulus(1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd12, 32'hC);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        rf_bus.wr_hold = 1'b0;
        #1;
        checkOutput("rstd_count", 32'(count), 3);
        checkOutput("rstd_wreg", 32'(rf_bus.write_register), 10);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rstd_wr_en_in_rst", 32'(rf_bus.wr_en), 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstd_count_after", 32'(count), 0);
        checkOutput("rstd_wr_en_after", 32'(rf_bus.wr_en), 0);
        checkOutput("rstd_pend_after", pend_mask, 0);
        checkOutput("rstd_wreg_after", 32'(rf_bus.write_register), 0);
        tick();
        tick();
        tick();

        // Every committed write, in order
        checkOutput("log_size", 32'(wr_log.size()), 11);
        for (int i = 0; i < 11 && i < wr_log.size(); i++) begin
            checkOutput($sformatf("log_rd%0d", i), 32'(wr_log[i][ADDR_W+DATA_W-1:DATA_W]), 32'(exp_rd[i]));
            checkOutput($sformatf("log_data%0d", i), wr_log[i][DATA_W-1:0], exp_data[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
